count_display_scan: RTL and testbench

//  Downstream consumer of the 4-bit binary counter stage. Synchronises the counter's Q and RCO

---
 rtl/seg7_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/count_display_scan.sv | 104 ++++++++++
 tb/tb_count_display_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants for the count display scanner
package seg7_pkg;

  localparam int IDX_W = 2;
  typedef logic [IDX_W-1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}; entry n is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/count_display_scan.sv
// rtl/count_display_scan.sv - syncs counter Q/RCO, counts RCO wraps, scans 4-digit 7-seg display
module count_display_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] q_in,
  input  logic       rco_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [SYNC_STG-1:0][3:0] q_sync_q;
  logic [SYNC_STG-1:0]      rco_sync_q;
  logic                     rco_d_q;
  logic [7:0]               wrap_cnt_q, wrap_cnt_d;
  logic [PW-1:0]            presc_q, presc_d;
  digit_idx_t               idx_q, idx_d;
  logic [3:0]               an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;

  logic [3:0] q_s;
  logic       rco_s, rco_rise, tick, blank;
  logic [3:0] digit_nib;
  logic [6:0] digit_seg;

  assign q_s      = q_sync_q[SYNC_STG-1];
  assign rco_s    = rco_sync_q[SYNC_STG-1];
  assign rco_rise = rco_s & ~rco_d_q;
  assign tick     = (presc_q == PRESC_MAX);

  hex_to_seg7 u_dec (
    .hex_i (digit_nib),
    .seg_o (digit_seg)
  );

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    idx_d      = tick ? idx_q + 1'b1 : idx_q;
    wrap_cnt_d = wrap_cnt_q + 8'(rco_rise);
    digit_nib  = 4'h0;
    blank      = 1'b0;
    an_d       = AN_OFF;
    dp_d       = 1'b1;
    // Outputs follow the current index; the index change reaches the pins one clk later.
    case (idx_q)
      2'd0: begin
        an_d      = 4'b1110;
        digit_nib = q_s;
        dp_d      = ~rco_s;
      end
      2'd1: begin
        an_d      = 4'b1101;
        digit_nib = wrap_cnt_q[3:0];
      end
      2'd2: begin
        an_d      = 4'b1011;
        digit_nib = wrap_cnt_q[7:4];
      end
      default: begin
        an_d  = 4'b0111;
        blank = 1'b1;
      end
    endcase
    seg_d = blank ? SEG_BLANK : digit_seg;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_sync_q   <= '0;
      rco_sync_q <= '0;
      rco_d_q    <= 1'b0;
      wrap_cnt_q <= 8'h00;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      q_sync_q   <= {q_sync_q[SYNC_STG-2:0], q_in};
      rco_sync_q <= {rco_sync_q[SYNC_STG-2:0], rco_in};
      rco_d_q    <= rco_s;
      wrap_cnt_q <= wrap_cnt_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_count_display_scan.sv
// tb/tb_count_display_scan.sv - directed self-checking bench for count_display_scan
module tb_count_display_scan;

  localparam logic [6:0] H0 = 7'b1000000;
  localparam logic [6:0] H1 = 7'b1111001;
  localparam logic [6:0] H3 = 7'b0110000;
  localparam logic [6:0] H5 = 7'b0010010;
  localparam logic [6:0] HA = 7'b0001000;
  localparam logic [6:0] HF = 7'b0001110;
  localparam logic [6:0] BL = 7'h7F;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] q_in = 4'h0;
  logic       rco_in = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_display_scan #(.SCAN_DIV(4), .SYNC_STG(2)) dut (
    .clk    (clk),
    .clr    (clr),
    .q_in   (q_in),
    .rco_in (rco_in),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  function automatic logic [3:0] slot_an(input int k);
    case (((k - 1) / 4) % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Ends on the negedge just before the first posedge with clr low.
  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    rco_in = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    rco_in = 1'b1;
    repeat (hi) @(negedge clk);
    rco_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] want, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (an === want) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting an=%b last=%b", name, want, an);
    end
  endtask

  task automatic test_reset();
    q_in = 4'h5;
    do_reset();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
    checks++; if (seg !== BL) begin errors++; $display("FAIL reset_seg got %b exp %b", seg, BL); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
  endtask

  task automatic test_scan();
    logic [6:0] eseg;
    q_in = 4'h5;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      case (((k - 1) / 4) % 4)
        0:       eseg = (k < 3) ? H0 : H5;
        1, 2:    eseg = H0;
        default: eseg = BL;
      endcase
      checks++; if (an !== slot_an(k)) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, slot_an(k)); end
      checks++; if (seg !== eseg) begin errors++; $display("FAIL scan_seg k=%0d got %b exp %b", k, seg, eseg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp k=%0d got %b exp 1", k, dp); end
    end
  endtask

  task automatic test_rco_pulses();
    logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    logic edp;
    int k = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 40; c++) begin
        rco_in = (c < 20);
        h2 = h1; h1 = h0; h0 = rco_in;
        @(negedge clk);
        k++;
        edp = (slot_an(k) == 4'b1110) ? ~h2 : 1'b1;
        checks++; if (dp !== edp) begin errors++; $display("FAIL rco_dp k=%0d got %b exp %b", k, dp, edp); end
      end
    end
    while (k < 140) begin
      @(negedge clk);
      k++;
      if (k == 133) begin
        checks++; if (an !== 4'b1101 || seg !== H3) begin errors++; $display("FAIL rco_lo an=%b seg=%b exp 1101 %b", an, seg, H3); end
      end
      if (k == 137) begin
        checks++; if (an !== 4'b1011 || seg !== H0) begin errors++; $display("FAIL rco_hi an=%b seg=%b exp 1011 %b", an, seg, H0); end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (255) pulse(3, 3);
    wait_an(4'b1101, "wrap255_lo");
    checks++; if (seg !== HF) begin errors++; $display("FAIL wrap255_lo got %b exp %b", seg, HF); end
    wait_an(4'b1011, "wrap255_hi");
    checks++; if (seg !== HF) begin errors++; $display("FAIL wrap255_hi got %b exp %b", seg, HF); end
    pulse(3, 3);
    wait_an(4'b1101, "wrap256_lo");
    checks++; if (seg !== H0) begin errors++; $display("FAIL wrap256_lo got %b exp %b", seg, H0); end
    wait_an(4'b1011, "wrap256_hi");
    checks++; if (seg !== H0) begin errors++; $display("FAIL wrap256_hi got %b exp %b", seg, H0); end
  endtask

  task automatic test_tick_edge();
    int k = 5;
    do_reset();
    repeat (5) @(negedge clk);
    rco_in = 1'b1;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 15) rco_in = 1'b0;
      if (k == 8) begin
        checks++; if (an !== 4'b1101 || seg !== H0) begin errors++; $display("FAIL tick_k8 an=%b seg=%b exp 1101 %b", an, seg, H0); end
      end
      if (k == 9) begin
        checks++; if (an !== 4'b1011 || seg !== H0) begin errors++; $display("FAIL tick_k9 an=%b seg=%b exp 1011 %b", an, seg, H0); end
      end
      if (k == 21 || k == 37) begin
        checks++; if (an !== 4'b1101 || seg !== H1) begin errors++; $display("FAIL tick_cnt k=%0d an=%b seg=%b exp 1101 %b", k, an, seg, H1); end
      end
    end
  endtask

  task automatic test_clr_mid();
    q_in = 4'h5;
    do_reset();
    repeat (58) pulse(3, 3);
    wait_an(4'b1101, "mid_lo");
    checks++; if (seg !== HA) begin errors++; $display("FAIL mid_lo got %b exp %b", seg, HA); end
    wait_an(4'b1011, "mid_hi");
    checks++; if (seg !== H3) begin errors++; $display("FAIL mid_hi got %b exp %b", seg, H3); end
    clr = 1'b1;
    @(negedge clk);
    checks++; if (an !== 4'b1111 || seg !== BL || dp !== 1'b1) begin errors++; $display("FAIL mid_clr an=%b seg=%b dp=%b exp 1111 %b 1", an, seg, dp, BL); end
    clr = 1'b0;
    @(negedge clk);
    checks++; if (an !== 4'b1110 || seg !== H0) begin errors++; $display("FAIL mid_idx0 an=%b seg=%b exp 1110 %b", an, seg, H0); end
    repeat (4) @(negedge clk);
    checks++; if (an !== 4'b1101 || seg !== H0) begin errors++; $display("FAIL mid_cnt an=%b seg=%b exp 1101 %b", an, seg, H0); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_rco_pulses();
    test_wrap();
    test_tick_edge();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
